// File: rtl/rice_core_pkg.sv
// Shared types and helpers for the rice core's instruction-side blocks.
//   rice_inst_response_t    : one instruction-bus response {data, error}
//   rice_inst_address_error : access-fault decode for a word-addressed memory
package rice_core_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } rice_inst_response_t;

  // Misaligned, below base, or at/after base + 4*words. The compare runs one
  // bit wider than the operands so a range ending at the top of the address
  // space cannot wrap back to zero.
  function automatic logic rice_inst_address_error(
    input logic [63:0] address,
    input logic [63:0] base,
    input logic [63:0] words
  );
    logic [64:0] addr_x;
    logic [64:0] base_x;
    logic [64:0] limit_x;
    addr_x  = {1'b0, address};
    base_x  = {1'b0, base};
    limit_x = base_x + ({1'b0, words} << 2);
    return (address[1:0] != 2'b00) || (addr_x < base_x) || (addr_x >= limit_x);
  endfunction

endpackage

// File: rtl/rice_inst_response_fifo.sv
// In-order response FIFO for the instruction-bus responder.
//   i_clk, i_rst      : clock, asynchronous active-high reset (pointers only)
//   i_push/i_push_entry : write one entry at the tail
//   i_pop             : remove the head entry (ignored when empty)
//   o_empty, o_full   : occupancy flags
//   o_head            : head entry, stable until popped
module rice_inst_response_fifo
  import rice_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_push,
  input  rice_inst_response_t i_push_entry,
  input  logic                i_pop,
  output logic                o_empty,
  output logic                o_full,
  output rice_inst_response_t o_head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rice_inst_response_t mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                do_pop;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = i_pop && !o_empty;
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_head  = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (i_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({i_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q] <= i_push_entry;
  end

endmodule

// File: rtl/rice_inst_bus_responder.sv
// Responder end of the instruction bus: returns 32-bit words from an internal
// word-addressed memory, in order, LATENCY+1 cycles after accept at minimum,
// with at most OUTSTANDING requests in flight.
//   i_clk, i_rst                : clock, asynchronous active-high reset
//   i_request_valid/o_request_ready/i_address : fetch request
//   o_response_valid/i_response_ready          : response handshake
//   o_response_data/o_response_error           : instruction word / access fault
//   i_load_valid/i_load_address/i_load_data    : preload write port
module rice_inst_bus_responder
  import rice_core_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              WORDS        = 4096,
  parameter logic [XLEN-1:0] BASE_ADDRESS = '0,
  parameter int              LATENCY      = 1,
  parameter int              OUTSTANDING  = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_request_valid,
  output logic            o_request_ready,
  input  logic [XLEN-1:0] i_address,
  output logic            o_response_valid,
  input  logic            i_response_ready,
  output logic [31:0]     o_response_data,
  output logic            o_response_error,
  input  logic            i_load_valid,
  input  logic [XLEN-1:0] i_load_address,
  input  logic [31:0]     i_load_data
);

  localparam int AW = $clog2(WORDS);
  localparam int CW = $clog2(OUTSTANDING + 1);

  logic [31:0]         mem_q [WORDS];
  logic [CW-1:0]       count_q;
  logic                accept;
  logic                handshake;
  logic                req_err;
  logic                load_err;
  logic [AW-1:0]       req_idx;
  logic [AW-1:0]       load_idx;
  logic [LATENCY-1:0]  vld_p;
  rice_inst_response_t resp_p [LATENCY];
  logic                fifo_empty;
  logic                fifo_full;
  rice_inst_response_t fifo_head;

  assign accept    = i_request_valid && o_request_ready;
  assign handshake = o_response_valid && i_response_ready;
  assign req_err   = rice_inst_address_error(64'(i_address), 64'(BASE_ADDRESS), 64'(WORDS));
  assign load_err  = rice_inst_address_error(64'(i_load_address), 64'(BASE_ADDRESS), 64'(WORDS));
  assign req_idx   = i_address[AW+1:2];
  assign load_idx  = i_load_address[AW+1:2];

  // Credit: ready is decoded purely from the registered count.
  assign o_request_ready = (count_q < CW'(OUTSTANDING));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (accept && !handshake) begin
      count_q <= count_q + 1'b1;
    end else if (handshake && !accept) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Preload port; nonblocking write means a same-cycle read sees old data.
  always_ff @(posedge i_clk) begin
    if (i_load_valid && !load_err) mem_q[load_idx] <= i_load_data;
  end

  // Stage p0: memory read on accept. Later stages: plain shift, no stall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      resp_p[0].error <= req_err;
      resp_p[0].data  <= req_err ? 32'h0 : mem_q[req_idx];
    end
    for (int i = 1; i < LATENCY; i++) resp_p[i] <= resp_p[i-1];
  end

  // Last pipe stage -> response buffer.
  rice_inst_response_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_response_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (vld_p[LATENCY-1]),
    .i_push_entry (resp_p[LATENCY-1]),
    .i_pop        (handshake),
    .o_empty      (fifo_empty),
    .o_full       (fifo_full),
    .o_head       (fifo_head)
  );

  // Buffer storage is not reset, so outputs are forced to zero while empty.
  assign o_response_valid = !fifo_empty;
  assign o_response_data  = fifo_empty ? 32'h0 : fifo_head.data;
  assign o_response_error = fifo_empty ? 1'b0  : fifo_head.error;

  // The credit counter bounds in-flight requests to the buffer depth.
  always_ff @(posedge i_clk) begin
    if (!i_rst) assert (!(vld_p[LATENCY-1] && fifo_full && !handshake));
  end

endmodule

// File: tb/tb_rice_inst_bus_responder.sv
module tb_rice_inst_bus_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_req_v, a_req_rdy, a_rsp_v, a_rsp_rdy, a_rsp_err, a_ld_v;
  logic [31:0] a_addr, a_rsp_d, a_ld_addr, a_ld_d;
  logic        b_req_v, b_req_rdy, b_rsp_v, b_rsp_rdy, b_rsp_err, b_ld_v;
  logic [31:0] b_addr, b_rsp_d, b_ld_addr, b_ld_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rice_inst_bus_responder #(
    .XLEN(32), .WORDS(16), .BASE_ADDRESS(32'h0000_0000), .LATENCY(1), .OUTSTANDING(2)
  ) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_request_valid(a_req_v), .o_request_ready(a_req_rdy), .i_address(a_addr),
    .o_response_valid(a_rsp_v), .i_response_ready(a_rsp_rdy),
    .o_response_data(a_rsp_d), .o_response_error(a_rsp_err),
    .i_load_valid(a_ld_v), .i_load_address(a_ld_addr), .i_load_data(a_ld_d)
  );

  rice_inst_bus_responder #(
    .XLEN(32), .WORDS(16), .BASE_ADDRESS(32'h0000_1000), .LATENCY(4), .OUTSTANDING(4)
  ) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_request_valid(b_req_v), .o_request_ready(b_req_rdy), .i_address(b_addr),
    .o_response_valid(b_rsp_v), .i_response_ready(b_rsp_rdy),
    .o_response_data(b_rsp_d), .o_response_error(b_rsp_err),
    .i_load_valid(b_ld_v), .i_load_address(b_ld_addr), .i_load_data(b_ld_d)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_load(input logic [31:0] addr, input logic [31:0] data);
    a_ld_v = 1'b1; a_ld_addr = addr; a_ld_d = data;
    tick;
    a_ld_v = 1'b0;
  endtask

  task automatic b_load(input logic [31:0] addr, input logic [31:0] data);
    b_ld_v = 1'b1; b_ld_addr = addr; b_ld_d = data;
    tick;
    b_ld_v = 1'b0;
  endtask

  // One request on dut_a (LATENCY=1) with i_response_ready held high.
  task automatic a_single(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_d, input logic exp_e);
    a_req_v = 1'b1; a_addr = addr;
    tick;
    a_req_v = 1'b0;
    chk({tag, "_early"}, 32'(a_rsp_v), 32'd0);
    tick;
    chk({tag, "_valid"}, 32'(a_rsp_v), 32'd1);
    chk({tag, "_data"},  a_rsp_d, exp_d);
    chk({tag, "_err"},   32'(a_rsp_err), 32'(exp_e));
    tick;
    chk({tag, "_drained"}, 32'(a_rsp_v), 32'd0);
  endtask

  // One request on dut_b (LATENCY=4) with i_response_ready held high.
  task automatic b_single(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_d, input logic exp_e);
    b_req_v = 1'b1; b_addr = addr;
    tick;
    b_req_v = 1'b0;
    repeat (3) tick;
    chk({tag, "_early"}, 32'(b_rsp_v), 32'd0);
    tick;
    chk({tag, "_valid"}, 32'(b_rsp_v), 32'd1);
    chk({tag, "_data"},  b_rsp_d, exp_d);
    chk({tag, "_err"},   32'(b_rsp_err), 32'(exp_e));
    tick;
    chk({tag, "_drained"}, 32'(b_rsp_v), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_req_v = 0; a_addr = 0; a_rsp_rdy = 0; a_ld_v = 0; a_ld_addr = 0; a_ld_d = 0;
    b_req_v = 0; b_addr = 0; b_rsp_rdy = 0; b_ld_v = 0; b_ld_addr = 0; b_ld_d = 0;
    repeat (2) tick;

    // Reset values
    chk("rst_a_ready", 32'(a_req_rdy), 32'd1);
    chk("rst_a_valid", 32'(a_rsp_v),   32'd0);
    chk("rst_a_data",  a_rsp_d,        32'd0);
    chk("rst_a_err",   32'(a_rsp_err), 32'd0);
    chk("rst_b_ready", 32'(b_req_rdy), 32'd1);
    chk("rst_b_valid", 32'(b_rsp_v),   32'd0);
    rst = 1'b0;
    tick;

    // Preloads, including ignored out-of-range / misaligned writes that would
    // alias onto live words if they were not filtered.
    a_load(32'h0000_0000, 32'h0000_0013);
    a_load(32'h0000_0004, 32'h0010_0093);
    a_load(32'h0000_0008, 32'h0000_0000);
    a_load(32'h0000_003C, 32'h1234_5678);
    a_load(32'h0000_0040, 32'hBAD0_0001);
    a_load(32'h0000_0005, 32'hBAD0_0002);
    b_load(32'h0000_1000, 32'hAAAA_0001);
    b_load(32'h0000_1004, 32'hAAAA_0002);
    b_load(32'h0000_1008, 32'hAAAA_0003);
    b_load(32'h0000_103C, 32'h5555_5555);
    b_load(32'h0000_0FFC, 32'hBAD0_0003);
    b_load(32'h0000_1040, 32'hBAD0_0004);

    // Back-to-back fetches, LATENCY=1
    a_rsp_rdy = 1'b1;
    a_req_v = 1'b1; a_addr = 32'h0;
    tick;
    chk("t1_c1_valid", 32'(a_rsp_v), 32'd0);
    a_addr = 32'h4;
    tick;
    a_req_v = 1'b0;
    chk("t1_c2_valid", 32'(a_rsp_v), 32'd1);
    chk("t1_c2_data",  a_rsp_d, 32'h0000_0013);
    chk("t1_c2_err",   32'(a_rsp_err), 32'd0);
    tick;
    chk("t1_c3_valid", 32'(a_rsp_v), 32'd1);
    chk("t1_c3_data",  a_rsp_d, 32'h0010_0093);
    tick;
    chk("t1_c4_valid", 32'(a_rsp_v), 32'd0);

    // Credit limit with response backpressure
    a_rsp_rdy = 1'b0;
    a_req_v = 1'b1; a_addr = 32'h0;
    tick;
    chk("t2_c1_ready", 32'(a_req_rdy), 32'd1);
    a_addr = 32'h4;
    tick;
    a_addr = 32'h8;
    chk("t2_c2_ready", 32'(a_req_rdy), 32'd0);
    tick;
    chk("t2_c3_ready", 32'(a_req_rdy), 32'd0);
    chk("t2_c3_data",  a_rsp_d, 32'h0000_0013);
    a_rsp_rdy = 1'b1;
    tick;
    a_rsp_rdy = 1'b0;
    chk("t2_c4_ready", 32'(a_req_rdy), 32'd1);
    chk("t2_c4_data",  a_rsp_d, 32'h0010_0093);
    tick;
    a_req_v = 1'b0;
    chk("t2_c5_ready", 32'(a_req_rdy), 32'd0);
    chk("t2_c5_hold",  a_rsp_d, 32'h0010_0093);
    a_rsp_rdy = 1'b1;
    tick;
    chk("t2_c6_valid", 32'(a_rsp_v), 32'd1);
    chk("t2_c6_data",  a_rsp_d, 32'h0000_0000);
    chk("t2_c6_err",   32'(a_rsp_err), 32'd0);
    tick;
    chk("t2_c7_valid", 32'(a_rsp_v), 32'd0);
    chk("t2_c7_ready", 32'(a_req_rdy), 32'd1);

    // Access faults and range edges
    a_single("t3_misaligned", 32'h0000_0002, 32'h0, 1'b1);
    a_single("t3_top",        32'h0000_0040, 32'h0, 1'b1);
    a_single("t3_nowrap",     32'hFFFF_FFFC, 32'h0, 1'b1);
    a_single("t3_last",       32'h0000_003C, 32'h1234_5678, 1'b0);
    a_single("t3_word1",      32'h0000_0004, 32'h0010_0093, 1'b0);

    // LATENCY=4 streaming, first response at accept+5
    b_rsp_rdy = 1'b1;
    b_req_v = 1'b1; b_addr = 32'h1000;
    tick;
    chk("t4_c1_ready", 32'(b_req_rdy), 32'd1);
    b_addr = 32'h1004;
    tick;
    b_addr = 32'h1008;
    tick;
    b_req_v = 1'b0;
    chk("t4_c3_valid", 32'(b_rsp_v), 32'd0);
    tick;
    chk("t4_c4_valid", 32'(b_rsp_v), 32'd0);
    tick;
    chk("t4_c5_valid", 32'(b_rsp_v), 32'd1);
    chk("t4_c5_data",  b_rsp_d, 32'hAAAA_0001);
    tick;
    chk("t4_c6_data",  b_rsp_d, 32'hAAAA_0002);
    tick;
    chk("t4_c7_data",  b_rsp_d, 32'hAAAA_0003);
    tick;
    chk("t4_c8_valid", 32'(b_rsp_v), 32'd0);

    b_single("t4_below_base", 32'h0000_0FFC, 32'h0, 1'b1);
    b_single("t4_above_top",  32'h0000_1040, 32'h0, 1'b1);
    b_single("t4_last",       32'h0000_103C, 32'h5555_5555, 1'b0);

    // Asynchronous reset with two requests in flight
    a_rsp_rdy = 1'b0;
    a_req_v = 1'b1; a_addr = 32'h0;
    tick;
    a_addr = 32'h4;
    tick;
    a_req_v = 1'b0;
    chk("t5_pre_valid", 32'(a_rsp_v), 32'd1);
    chk("t5_pre_ready", 32'(a_req_rdy), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_ready", 32'(a_req_rdy), 32'd1);
    chk("t5_async_valid", 32'(a_rsp_v),   32'd0);
    chk("t5_async_data",  a_rsp_d,        32'd0);
    chk("t5_async_err",   32'(a_rsp_err), 32'd0);
    tick;
    rst = 1'b0;
    repeat (3) tick;
    chk("t5_post_valid", 32'(a_rsp_v),   32'd0);
    chk("t5_post_ready", 32'(a_req_rdy), 32'd1);
    a_rsp_rdy = 1'b1;
    a_single("t5_after", 32'h0000_0004, 32'h0010_0093, 1'b0);

    // Load and read of the same word in one cycle
    a_req_v = 1'b1; a_addr = 32'h8;
    a_ld_v = 1'b1; a_ld_addr = 32'h8; a_ld_d = 32'hDEAD_BEEF;
    tick;
    a_req_v = 1'b0; a_ld_v = 1'b0;
    tick;
    chk("t6_old_valid", 32'(a_rsp_v), 32'd1);
    chk("t6_old_data",  a_rsp_d, 32'h0000_0000);
    tick;
    a_single("t6_new", 32'h0000_0008, 32'hDEAD_BEEF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
